red_mc: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle register-file/ALU datapath.
- Contains:
  - a 2^ADDRESS_WIDTH x DATA_WIDTH register file (x0 hardwired to zero);
  - an immediate/register operand select;
  - an extended single-cycle ALU;
  - an iterative shift-add multiplier.
- A valid/ready issue handshake stalls new operations while a multiply runs.
- The full-width a0 register is exported for the top-level test harness.

---
 rtl/red_mc.sv | 195 +++++++++++++++++++
 tb/tb_red_mc.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/red_mc.sv
// red_mc: multi-cycle register-file / ALU datapath.
//
// Holds a 2^ADDRESS_WIDTH x DATA_WIDTH register file (x0 reads zero), an
// immediate/register operand select, a single-cycle ALU and an iterative
// shift-add multiplier. New operations are accepted through a valid/ready
// handshake. in_ready drops while a multiply is in progress.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active low
//   in_valid  operation presented this cycle
//   in_ready  block can accept an operation (high only when idle)
//   ad1, ad2  source register indices
//   ad3       destination register index
//   we3       write result to ad3
//   aluSrc    0: operand 2 = rd2, 1: operand 2 = immOp
//   aluCTR    operation select
//   immOp     immediate operand
//   eq        combinational rd1 == operand 2
//   a0        contents of register A0_INDEX
//   done      one-cycle pulse after a register write commits
module red_mc #(
    parameter int unsigned ADDRESS_WIDTH = 5,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned A0_INDEX      = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDRESS_WIDTH-1:0] ad1,
    input  logic [ADDRESS_WIDTH-1:0] ad2,
    input  logic [ADDRESS_WIDTH-1:0] ad3,
    input  logic                     we3,
    input  logic                     aluSrc,
    input  logic [3:0]               aluCTR,
    input  logic [DATA_WIDTH-1:0]    immOp,
    output logic                     eq,
    output logic [DATA_WIDTH-1:0]    a0,
    output logic                     done
);

    localparam int unsigned NumRegs = 2 ** ADDRESS_WIDTH;
    localparam int unsigned ShW     = $clog2(DATA_WIDTH);

    localparam logic [ADDRESS_WIDTH-1:0] A0Addr  = ADDRESS_WIDTH'(A0_INDEX);
    localparam logic [ShW-1:0]           CntLast = ShW'(DATA_WIDTH - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StMul  = 2'd1;
    localparam logic [1:0] StWb   = 2'd2;

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSll  = 4'b0101;
    localparam logic [3:0] OpSrl  = 4'b0110;
    localparam logic [3:0] OpSra  = 4'b0111;
    localparam logic [3:0] OpSlt  = 4'b1000;
    localparam logic [3:0] OpSltu = 4'b1001;
    localparam logic [3:0] OpMul  = 4'b1010;
    localparam logic [3:0] OpPass = 4'b1011;

    logic [DATA_WIDTH-1:0]    regs [NumRegs];
    logic [DATA_WIDTH-1:0]    rd1, rd2, op2, alu_res;
    logic [ShW-1:0]           shamt;

    logic [1:0]               state_q, state_d;
    logic [DATA_WIDTH-1:0]    mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0]    mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic [ShW-1:0]           cnt_q, cnt_d;
    logic [ADDRESS_WIDTH-1:0] cap_ad3_q, cap_ad3_d;
    logic                     cap_we3_q, cap_we3_d;
    logic                     done_q, done_d;

    logic                     wr_en;
    logic [ADDRESS_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]    wr_data;

    // Reads see the pre-edge contents, so a same-cycle write returns the old value.
    assign rd1   = (ad1 == '0) ? '0 : regs[ad1];
    assign rd2   = (ad2 == '0) ? '0 : regs[ad2];
    assign op2   = aluSrc ? immOp : rd2;
    assign shamt = op2[ShW-1:0];

    assign eq       = (rd1 == op2);
    assign a0       = regs[A0Addr];
    assign in_ready = (state_q == StIdle);
    assign done     = done_q;

    always_comb begin
        alu_res = '0;
        case (aluCTR)
            OpAdd:   alu_res = rd1 + op2;
            OpSub:   alu_res = rd1 - op2;
            OpAnd:   alu_res = rd1 & op2;
            OpOr:    alu_res = rd1 | op2;
            OpXor:   alu_res = rd1 ^ op2;
            OpSll:   alu_res = rd1 << shamt;
            OpSrl:   alu_res = rd1 >> shamt;
            OpSra:   alu_res = $signed(rd1) >>> shamt;
            OpSlt:   alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(rd1) < $signed(op2)};
            OpSltu:  alu_res = {{(DATA_WIDTH-1){1'b0}}, rd1 < op2};
            OpPass:  alu_res = op2;
            default: alu_res = '0;  // MUL goes through the FSM; 11xx reserved
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        cap_ad3_d = cap_ad3_q;
        cap_we3_d = cap_we3_q;
        done_d    = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = ad3;
        wr_data   = alu_res;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (aluCTR == OpMul) begin
                        state_d   = StMul;
                        mcand_d   = rd1;
                        mplier_d  = op2;
                        acc_d     = '0;
                        cnt_d     = '0;
                        cap_ad3_d = ad3;
                        cap_we3_d = we3;
                    end else begin
                        wr_en  = we3 && (ad3 != '0);
                        done_d = wr_en;
                    end
                end
            end
            StMul: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                wr_en   = cap_we3_q && (cap_ad3_q != '0);
                wr_addr = cap_ad3_q;
                wr_data = acc_q;
                done_d  = wr_en;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            cap_ad3_q <= '0;
            cap_we3_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cap_ad3_q <= cap_ad3_d;
            cap_we3_q <= cap_we3_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_red_mc.sv
// Bench for red_mc: issues directed and random operations, mirrors every
// register write in an architectural register model, and expects a done
// pulse per committed write with a0 matching the model's x10.
module tb_red_mc;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam logic [3:0] ADD = 4'd0, SLT = 4'd8, SLTU = 4'd9, SRA = 4'd7;
    localparam logic [3:0] MUL = 4'd10, PASS = 4'd11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] ad1 = '0, ad2 = '0, ad3 = '0;
    logic          we3 = 1'b0, aluSrc = 1'b0;
    logic [3:0]    aluCTR = '0;
    logic [DW-1:0] immOp = '0;
    logic          eq;
    logic [DW-1:0] a0;
    logic          done;

    red_mc #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .A0_INDEX(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ad1(ad1), .ad2(ad2), .ad3(ad3), .we3(we3), .aluSrc(aluSrc),
        .aluCTR(aluCTR), .immOp(immOp), .eq(eq), .a0(a0), .done(done)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] mreg [32];
    logic [DW-1:0] exp_q [$];
    bit            fresh = 1'b1;
    bit            last_mul = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural meaning of each operation.
    function automatic logic [DW-1:0] ref_alu(input logic [3:0] ctr, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic [63:0] p;
        int          sh;
        sh = int'(b % DW);
        case (ctr)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return $signed(a) >>> sh;
            4'd8:    return ($signed(a) < $signed(b)) ? 1 : 0;
            4'd9:    return (a < b) ? 1 : 0;
            4'd10: begin
                p = {32'd0, a} * {32'd0, b};
                return p[DW-1:0];
            end
            4'd11:   return b;
            default: return '0;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mreg[i] = '0;
    endtask

    // Presents an op at a falling edge, waits for in_ready, updates the model
    // and returns just after the accepting rising edge with in_valid still high.
    task automatic issue(input logic [3:0] ctr, input bit src, input int a1, input int a2,
                         input int a3, input bit we, input logic [DW-1:0] imm);
        int            stalls;
        logic [DW-1:0] rd1, op2, res;
        @(negedge clk);
        aluCTR = ctr; aluSrc = src; immOp = imm; we3 = we;
        ad1 = AW'(a1); ad2 = AW'(a2); ad3 = AW'(a3);
        in_valid = 1'b1;
        stalls = 0;
        while (!in_ready) begin
            @(negedge clk);
            stalls++;
            if (stalls > 200) begin
                errors++;
                $display("FAIL in_ready_timeout: still low after %0d cycles, expected high", stalls);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1, "in_ready stuck low");
            end
        end
        if (!fresh) chk("busy_cycles", 64'(stalls), last_mul ? 64'(DW + 1) : 64'd0);
        rd1 = mreg[a1];
        op2 = src ? imm : mreg[a2];
        #1;
        chk("eq", 64'(eq), 64'(rd1 == op2));
        res = ref_alu(ctr, rd1, op2);
        if (we && a3 != 0) begin
            mreg[a3] = res;
            exp_q.push_back(mreg[10]);
        end
        fresh = 1'b0;
        last_mul = (ctr == MUL);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        fresh = 1'b1;
    endtask

    // Monitor: every done pulse must match the oldest outstanding write.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with a0=%0h, expected no write", a0);
            end else begin
                chk("a0_on_done", 64'(a0), 64'(exp_q.pop_front()));
            end
        end
    end

    logic [DW-1:0] specials [6];

    initial begin
        specials[0] = 32'h0;        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
        specials[4] = 32'd1;        specials[5] = 32'd31;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_a0", 64'(a0), 64'd0);
        chk("reset_done", 64'(done), 64'd0);

        // Immediate ADD into x10, then a write to x0 that must not pulse done.
        issue(ADD, 1, 0, 0, 10, 1, 5);
        issue(ADD, 1, 0, 0, 0, 1, 7);
        idle(2);
        chk("x10_after_add", 64'(a0), 64'd5);

        // Wraparound and compares on all-ones.
        issue(PASS, 1, 0, 0, 1, 1, 32'hFFFF_FFFF);
        issue(ADD, 1, 1, 0, 2, 1, 1);
        issue(PASS, 0, 0, 2, 10, 1, 0);
        issue(SLT, 1, 1, 0, 10, 1, 0);
        issue(SLTU, 1, 1, 0, 10, 1, 0);
        issue(SRA, 1, 1, 0, 10, 1, 4);
        idle(2);
        chk("sra_all_ones", 64'(a0), 64'hFFFF_FFFF);

        // 7*6 with a queued follower; busy length checked by the follower.
        issue(PASS, 1, 0, 0, 11, 1, 7);
        issue(MUL, 1, 11, 0, 10, 1, 6);
        issue(ADD, 1, 0, 0, 12, 1, 3);
        idle(2);
        chk("mul_7x6", 64'(a0), 64'd42);

        // Overflowing multiply; the follower presents ad3=5 during the multiply.
        issue(PASS, 1, 0, 0, 1, 1, 32'h8000_0000);
        issue(MUL, 1, 1, 0, 10, 1, 2);
        issue(PASS, 1, 0, 0, 5, 1, 32'h55);
        issue(PASS, 0, 0, 5, 10, 1, 0);
        idle(2);
        chk("x5_after_mul", 64'(a0), 64'h55);

        // Reset in the middle of a multiply.
        issue(MUL, 1, 11, 0, 10, 1, 6);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        clear_model();
        #2;
        chk("midreset_a0", 64'(a0), 64'd0);
        chk("midreset_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (in_ready !== 1'b1 || a0 !== '0) break;
        end
        chk("post_reset_ready", 64'(in_ready), 64'd1);
        chk("post_reset_a0", 64'(a0), 64'd0);
        fresh = 1'b1;
        issue(PASS, 0, 0, 11, 10, 1, 0);
        issue(PASS, 0, 0, 1, 10, 1, 0);

        // Read-before-write ordering and eq.
        issue(PASS, 1, 0, 0, 3, 1, 9);
        issue(ADD, 1, 3, 0, 4, 1, 0);
        issue(ADD, 1, 3, 0, 3, 1, 1);
        issue(PASS, 0, 0, 4, 10, 1, 0);
        issue(ADD, 1, 3, 0, 0, 0, 10);
        idle(1);
        chk("x4_old_value", 64'(a0), 64'd9);

        // Random traffic.
        for (int n = 0; n < 250; n++) begin
            logic [3:0]    c;
            logic [DW-1:0] imm;
            int            a3;
            c   = 4'($urandom_range(0, 15));
            imm = ($urandom_range(0, 2) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            a3  = ($urandom_range(0, 1) == 0) ? 10 : $urandom_range(0, 15);
            issue(c, 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15),
                  a3, $urandom_range(0, 7) != 0, imm);
            if ($urandom_range(0, 2) == 0)
                issue(PASS, 0, 0, $urandom_range(0, 15), 10, 1, 0);
            if ($urandom_range(0, 15) == 0) idle($urandom_range(1, 3));
        end

        idle(1);
        for (int w = 0; w < 100 && exp_q.size() != 0; w++) @(negedge clk);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
